digit_scan: RTL and testbench

Display back-end of the clock: consumes the per-digit strobe stream (`ce`/`digit`) produced by the RTC reader and drives a 6-digit multiplexed 7-segment display (HH MM SS). Incoming frames are collected into a shadow buffer and committed atomically, so the display never shows a partially updated time. It sits directly downstream of the RTC reader and directly drives the board's segment and digit-select pins.

---
 rtl/digit_scan.sv | 160 ++++++++++++++++
 tb/tb_digit_scan.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan.sv
// digit_scan: display back-end for the clock. Collects SOF-delimited frames
// of six digit codes into a shadow buffer and commits them atomically to the
// display buffer. Scans a 6-digit multiplexed, active-low 7-segment display
// with a one-cycle blank on every position change.
// Optional feature macro: DP_BLINK_EN. It blinks the colon decimal points
// at positions 1 and 3.
module digit_scan #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 500
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [4:0] digit,
  output logic [7:0] seg,
  output logic [5:0] sel,
  output logic       frame_err
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [4:0] C_BLANK = 5'h10;
  localparam logic [4:0] C_SOF   = 5'h1F;

  typedef enum logic {S_IDLE, S_COLLECT} state_e;

  state_e        state_q;
  logic [2:0]    idx_q;
  logic [4:0]    shadow_q [6];
  logic [4:0]    disp_q   [6];
  logic [PW-1:0] presc_q;
  logic [2:0]    pos_q;
  logic          drive_q;
  logic          tick;
  logic          is_sof;
  logic          is_data;
  logic          dp_w;

  // Active-low a..g pattern for a stored display code; anything else is blank
  function automatic logic [6:0] seg7(input logic [4:0] c);
    case (c)
      5'd0:    seg7 = 7'h40;
      5'd1:    seg7 = 7'h79;
      5'd2:    seg7 = 7'h24;
      5'd3:    seg7 = 7'h30;
      5'd4:    seg7 = 7'h19;
      5'd5:    seg7 = 7'h12;
      5'd6:    seg7 = 7'h02;
      5'd7:    seg7 = 7'h78;
      5'd8:    seg7 = 7'h00;
      5'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Classify the incoming code and detect the prescaler wrap
  always_comb begin
    is_sof  = (digit == C_SOF);
    is_data = (digit <= 5'd9) || (digit == C_BLANK);
    tick    = (presc_q == PW'(SCAN_DIV - 1));
  end

  // Frame collection FSM: the shadow fills and disp commits on the 6th data code
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      frame_err <= 1'b0;
      for (int unsigned i = 0; i < 6; i++) begin
        shadow_q[i] <= C_BLANK;
        disp_q[i]   <= C_BLANK;
      end
    end else begin
      frame_err <= 1'b0;
      if (ce) begin
        unique case (state_q)
          S_IDLE: begin
            if (is_sof) begin
              state_q <= S_COLLECT;
              idx_q   <= '0;
            end
          end
          S_COLLECT: begin
            if (is_sof) begin
              idx_q <= '0;
              if (idx_q != '0) frame_err <= 1'b1;
            end else if (is_data) begin
              shadow_q[idx_q] <= digit;
              if (idx_q == 3'd5) begin
                for (int unsigned i = 0; i < 5; i++) disp_q[i] <= shadow_q[i];
                disp_q[5] <= digit;
                state_q   <= S_IDLE;
                idx_q     <= '0;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end else begin
              frame_err <= 1'b1;
              state_q   <= S_IDLE;
              idx_q     <= '0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef DP_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;

  // Blink phase toggles every BLINK_DIV scan ticks, starting off
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (tick) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  // Colon points at positions 1 and 3 light while the phase is on
  always_comb dp_w = ~(blink_q && ((pos_q == 3'd1) || (pos_q == 3'd3)));
`else
  // BLINK_DIV only matters in the blink build; the point stays dark here
  localparam bit DP_OFF = (BLINK_DIV >= 1) || 1'b1;
  always_comb dp_w = DP_OFF;
`endif

  // Scan: blank for the tick cycle, then drive pos_q and step to the next position.
  // pos_q names the position shown after the pending tick, so it advances at
  // drive time; the visible order matches advancing on the tick.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      pos_q   <= '0;
      drive_q <= 1'b0;
      seg     <= 8'hFF;
      sel     <= 6'h3F;
    end else begin
      drive_q <= tick;
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        sel <= 6'h3F;
        seg <= 8'hFF;
      end else if (drive_q) begin
        sel   <= ~(6'b000001 << pos_q);
        seg   <= {dp_w, seg7(disp_q[pos_q])};
        pos_q <= (pos_q == 3'd5) ? '0 : pos_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan.sv
// tb_digit_scan: directed stimulus with a cycle-count based reference model
// of the display and framing rules, plus literal spot checks.
module tb_digit_scan;

  localparam int unsigned SD = 4;
  localparam int unsigned BD = 2;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic [4:0] digit = '0;
  logic [7:0] seg;
  logic [5:0] sel;
  logic       frame_err;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned err_pulses = 0;

  digit_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .ce        (ce),
    .digit     (digit),
    .seg       (seg),
    .sel       (sel),
    .frame_err (frame_err)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] glyph(input int c);
    case (c)
      0: glyph = 8'hC0;
      1: glyph = 8'hF9;
      2: glyph = 8'hA4;
      3: glyph = 8'hB0;
      4: glyph = 8'h99;
      5: glyph = 8'h92;
      6: glyph = 8'h82;
      7: glyph = 8'hF8;
      8: glyph = 8'h80;
      9: glyph = 8'h90;
      default: glyph = 8'hFF;
    endcase
  endfunction

  // Reference model: outputs follow from the edge count since reset release
  int unsigned edges;
  int          m_collect;
  int          m_idx;
  int          sbuf [6];
  int          mdisp [6];
  logic [7:0]  e_seg;
  logic [5:0]  e_sel;
  logic        e_err;

  always @(posedge sclk) begin
    int k;
    int p;
    if (!rst_n) begin
      edges = 0; m_collect = 0; m_idx = 0;
      for (int i = 0; i < 6; i++) begin sbuf[i] = 16; mdisp[i] = 16; end
      e_seg = 8'hFF; e_sel = 6'h3F; e_err = 1'b0;
    end else begin
      edges++;
      if (edges % SD == 0) begin
        e_sel = 6'h3F;
        e_seg = 8'hFF;
      end else if (edges % SD == 1 && edges > 1) begin
        k = int'((edges - 1) / SD);
        p = (k - 1) % 6;
        e_sel = ~(6'd1 << p);
        e_seg = glyph(mdisp[p]);
`ifdef DP_BLINK_EN
        if (((k / BD) % 2 == 1) && (p == 1 || p == 3)) e_seg[7] = 1'b0;
`endif
      end
      e_err = 1'b0;
      if (ce) begin
        if (digit == 5'h1F) begin
          if (m_collect == 1 && m_idx != 0) e_err = 1'b1;
          m_collect = 1;
          m_idx = 0;
        end else if (m_collect == 1) begin
          if (digit <= 5'd9 || digit == 5'h10) begin
            sbuf[m_idx] = int'(digit);
            m_idx++;
            if (m_idx == 6) begin
              mdisp = sbuf;
              m_collect = 0;
              m_idx = 0;
            end
          end else begin
            e_err = 1'b1;
            m_collect = 0;
            m_idx = 0;
          end
        end
      end
    end
  end

  // Compare DUT against the model on every cycle out of reset
  always @(negedge sclk) begin
    if (rst_n) begin
      chk("sel", {26'd0, sel}, {26'd0, e_sel});
      if (e_sel != 6'h3F) chk("seg", {24'd0, seg}, {24'd0, e_seg});
      chk("frame_err", {31'd0, frame_err}, {31'd0, e_err});
      if (frame_err) err_pulses++;
    end
  end

  task automatic put(input logic [4:0] d);
    @(negedge sclk);
    ce = 1'b1;
    digit = d;
  endtask

  task automatic idle(input int unsigned c);
    repeat (c) begin
      @(negedge sclk);
      ce = 1'b0;
    end
  endtask

  task automatic put_frame(input logic [4:0] a, b, c, d, e, f);
    put(a); put(b); put(c); put(d); put(e); put(f);
  endtask

  // Wait (bounded) for a given select, then check the literal segment value
  task automatic show_at(input string name, input logic [5:0] s, input logic [7:0] g);
    int unsigned w;
    w = 0;
    while (sel !== s && w < 60) begin
      @(negedge sclk);
      w++;
    end
    chk({name, "_sel"}, {26'd0, sel}, {26'd0, s});
    chk(name, {24'd0, seg}, {24'd0, g});
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_seg"}, {24'd0, seg}, 32'hFF);
    chk({name, "_sel"}, {26'd0, sel}, 32'h3F);
    chk({name, "_err"}, {31'd0, frame_err}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge sclk);
    chk_reset("rst");
    rst_n = 1'b1;

    // Idle scan: every position blank
    idle(20);
    show_at("blank_p2", 6'h3B, 8'hFF);

    // Frame 1..6 on consecutive cycles
    put(5'h1F);
    put_frame(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6);
    idle(2);
    show_at("f1_p0", 6'h3E, 8'hF9);
    show_at("f1_p5", 6'h1F, 8'h82);

    // Restart mid-frame: one error, then zeros commit
    put(5'h1F); put(5'd7); put(5'd8); put(5'h1F);
    put_frame(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    idle(2);
    chk("err_cnt_restart", err_pulses, 32'd1);
    show_at("f2_p4", 6'h2F, 8'hC0);

    // Invalid code aborts; trailing data in IDLE is ignored
    put(5'h1F); put(5'd3); put(5'h0C);
    put(5'd9); put(5'd9); put(5'd9); put(5'd9);
    idle(2);
    chk("err_cnt_invalid", err_pulses, 32'd2);
    show_at("f3_p2", 6'h3B, 8'hC0);

    // Double SOF at idx 0 is a silent restart; blank code passes through
    put(5'h1F); put(5'h1F);
    put_frame(5'd2, 5'd0, 5'd5, 5'd9, 5'h10, 5'd7);
    idle(2);
    chk("err_cnt_sof0", err_pulses, 32'd2);
    show_at("f4_p2", 6'h3B, 8'h92);
    show_at("f4_p4", 6'h2F, 8'hFF);
    show_at("f4_p5", 6'h1F, 8'hF8);

    // Reset mid-frame
    put(5'h1F); put(5'd1); put(5'd2); put(5'd3);
    @(negedge sclk);
    ce = 1'b0;
    rst_n = 1'b0;
    @(negedge sclk);
    chk_reset("midrst");
    @(negedge sclk);
    rst_n = 1'b1;
    put(5'd5); put(5'h0C);
    put(5'h1F);
    put_frame(5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9);
    idle(2);
    show_at("f5_p0", 6'h3E, 8'h90);
    show_at("f5_p4", 6'h2F, 8'h90);
    chk("err_cnt_final", err_pulses, 32'd2);

    idle(30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
